// File: rtl/framer_pkg.sv
// Shared types and constants for the serial sample framer.
// Optional feature macro: FRAMER_PARITY_EN (adds the PARITY state and parity check).
package framer_pkg;

  localparam int DATA_BITS = 6;
  localparam logic [1:0] HEADER = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
`ifdef FRAMER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Pack one decoded sample into the averager's byte layout.
  function automatic logic [7:0] pack_sample(input logic [1:0] t,
                                             input logic [1:0] y,
                                             input logic [1:0] x);
    return {HEADER, t, y, x};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with a zero-masked head output.
// A push while full is accepted only when a pop happens in the same cycle.
// Reset is synchronous and active-high on the pin named rst_n.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is taken straight from storage flops; no input reaches it combinationally.
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count masks stale entries.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sample_framer.sv
// Bit-serial sensor frame decoder feeding the moving-average stage.
// Frame: start(1), x1 x0 y1 y0 t1 t0, [parity], stop(0).
// Optional feature macro: FRAMER_PARITY_EN (even parity over the 6 data bits).
// Reset is synchronous and active-high; the pin keeps the name rst_n.
module sample_framer
  import framer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdi,
  input  logic                 sdi_valid,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 par_err;

  logic stop_sample;
  logic frame_good;
  logic frame_bad;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic drop;
  logic [7:0] packed_byte;

  assign busy        = (state != IDLE);
  assign stop_sample = (state == STOP) && sdi_valid;
  assign frame_good  = stop_sample && !sdi && !par_err;
  assign frame_bad   = stop_sample && (sdi || par_err);
  assign out_valid   = !fifo_empty;
  assign fifo_pop    = out_valid && out_ready;
  assign drop        = frame_good && fifo_full && !fifo_pop;
  // Shift register holds {x1, x0, y1, y0, t1, t0} once DATA completes.
  assign packed_byte = pack_sample(shift[1:0], shift[3:2], shift[5:4]);

`ifndef FRAMER_PARITY_EN
  assign par_err = 1'b0;
`endif

  // Frame FSM: advances only on valid bits, so sdi_valid=0 stalls it in place.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
`ifdef FRAMER_PARITY_EN
      par_err <= 1'b0;
`endif
    end else if (sdi_valid) begin
      case (state)
        IDLE: begin
          if (sdi) begin
            state   <= DATA;
            bit_cnt <= '0;
`ifdef FRAMER_PARITY_EN
            par_err <= 1'b0;
`endif
          end
        end
        DATA: begin
          shift <= {shift[DATA_BITS-2:0], sdi};
          if (bit_cnt == LAST_BIT) begin
`ifdef FRAMER_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef FRAMER_PARITY_EN
        PARITY: begin
          // Even parity: the parity bit equals the XOR of the data bits.
          par_err <= sdi ^ (^shift);
          state   <= STOP;
        end
`endif
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reject reporting and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      overflow  <= 1'b0;
    end else begin
      err_pulse <= frame_bad;
      if (frame_bad && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  sample_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (frame_good),
    .push_data (packed_byte),
    .pop       (fifo_pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every accepted output.
module tb_sample_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sdi;
  logic       sdi_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       err_pulse;
  logic [3:0] err_cnt;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];

  // Hand-packed vectors: data bits {x1,x0,y1,y0,t1,t0} -> {2'b11,t,y,x}.
  logic [5:0] dv [6] = '{6'b011011, 6'b000000, 6'b111111, 6'b100100, 6'b001110, 6'b110001};
  logic [7:0] bv [6] = '{8'hF9,     8'hC0,     8'hFF,     8'hC6,     8'hEC,     8'hD3};

  always #5 clk = ~clk;

  sample_framer #(
    .FIFO_DEPTH (4),
    .ERR_CNT_W  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sdi       (sdi),
    .sdi_valid (sdi_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the next expected byte.
  always @(negedge clk) begin
    if (!rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected nothing", out_data);
      end else begin
        check("scoreboard_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    if (err_pulse) err_seen++;
  end

  task automatic send_bit(input logic b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      sdi_valid = 1'b0;
      sdi = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    sdi = b;
    sdi_valid = 1'b1;
    @(posedge clk); #1;
    sdi_valid = 1'b0;
    sdi = 1'b0;
  endtask

  task automatic send_frame(input logic [5:0] d, input logic par_flip, input logic stop_b,
                            input int max_gap, input logic rdy_stop);
    send_bit(1'b1, max_gap);
    for (int i = 5; i >= 0; i--) send_bit(d[i], max_gap);
`ifdef FRAMER_PARITY_EN
    send_bit((^d) ^ par_flip, max_gap);
`else
    if (par_flip) $display("note: parity flip ignored in this build");
`endif
    if (rdy_stop) out_ready = 1'b1;
    send_bit(stop_b, max_gap);
    if (rdy_stop) out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    sdi = 1'b0;
    sdi_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    rst_n = 1'b0;

    // Good frame, one-cycle latency, busy window.
    out_ready = 1'b1;
    exp_q.push_back(8'hF9);
    send_bit(1'b1, 0);
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 5; i >= 0; i--) send_bit(dv[0][i], 0);
`ifdef FRAMER_PARITY_EN
    send_bit(^dv[0], 0);
`endif
    check("busy_before_stop", 32'(busy), 32'd1);
    send_bit(1'b0, 0);
    check("good_valid_n1", 32'(out_valid), 32'd1);
    check("good_data_n1",  32'(out_data),  32'hF9);
    check("good_busy_n1",  32'(busy),      32'd0);
    check("good_no_err",   32'(err_pulse), 32'd0);
    @(posedge clk); #1;
    check("good_drained_valid", 32'(out_valid), 32'd0);
    check("good_drained_data",  32'(out_data),  32'h00);
    check("good_err_cnt",       32'(err_cnt),   32'd0);

    // First reject: parity error when enabled, otherwise a stop error.
`ifdef FRAMER_PARITY_EN
    send_frame(dv[0], 1'b1, 1'b0, 0, 1'b0);
`else
    send_frame(dv[0], 1'b0, 1'b1, 0, 1'b0);
`endif
    check("rej_pulse_n1", 32'(err_pulse), 32'd1);
    check("rej_no_valid", 32'(out_valid), 32'd0);
    check("rej_err_cnt",  32'(err_cnt),   32'd1);
    @(posedge clk); #1;
    check("rej_pulse_n2", 32'(err_pulse), 32'd0);

    // Sixteen stop errors: counter saturates.
    repeat (16) send_frame(dv[1], 1'b0, 1'b1, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("err_cnt_sat",  32'(err_cnt), 32'hF);
    check("err_pulses",   32'(err_seen), 32'd17);
    check("rej_no_valid2", 32'(out_valid), 32'd0);

    // Fill the FIFO, then push into a full FIFO while popping.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(bv[i]);
      send_frame(dv[i], 1'b0, 1'b0, 0, 1'b0);
    end
    check("full_head", 32'(out_data), 32'(bv[1]));
    exp_q.push_back(bv[5]);
    send_frame(dv[5], 1'b0, 1'b0, 0, 1'b1);
    check("push_pop_full_ovf", 32'(overflow), 32'd0);
    check("push_pop_full_head", 32'(out_data), 32'(bv[2]));
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("drain1_empty_q", 32'(exp_q.size()), 32'd0);
    check("drain1_valid",   32'(out_valid), 32'd0);

    // Overflow: fifth good frame is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(bv[i]);
      send_frame(dv[i], 1'b0, 1'b0, 0, 1'b0);
      if (i == 3) check("ovf_before", 32'(overflow), 32'd0);
    end
    check("ovf_set",     32'(overflow), 32'd1);
    check("ovf_err_cnt", 32'(err_cnt),  32'hF);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_head_stable", 32'(out_data), 32'(bv[0]));
    check("ovf_sticky", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain2_empty_q", 32'(exp_q.size()), 32'd0);
    check("drain2_valid",   32'(out_valid), 32'd0);

    // Idle zeros and stalled frame.
    repeat (3) send_bit(1'b0, 2);
    check("idle_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'hF9);
    send_frame(dv[0], 1'b0, 1'b0, 3, 1'b0);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_data",  32'(out_data),  32'hF9);
    repeat (3) @(posedge clk);
    #1;
    check("stall_empty_q", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with one entry queued.
    out_ready = 1'b0;
    exp_q.push_back(bv[3]);
    send_frame(dv[3], 1'b0, 1'b0, 0, 1'b0);
    check("mid_queued", 32'(out_valid), 32'd1);
    send_bit(1'b1, 0);
    for (int i = 5; i >= 2; i--) send_bit(dv[0][i], 0);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_data",  32'(out_data),  32'h00);
    check("mrst_busy",      32'(busy),      32'd0);
    check("mrst_err_pulse", 32'(err_pulse), 32'd0);
    check("mrst_err_cnt",   32'(err_cnt),   32'd0);
    check("mrst_overflow",  32'(overflow),  32'd0);
    rst_n = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(bv[4]);
    send_frame(dv[4], 1'b0, 1'b0, 0, 1'b0);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data",  32'(out_data),  32'(bv[4]));
    repeat (3) @(posedge clk);
    #1;
    check("final_empty_q", 32'(exp_q.size()), 32'd0);
    check("final_err_cnt", 32'(err_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
# sample_framer

Serial-to-packed sample framer that sits directly upstream of the moving-average stage. It receives bit-serial sensor frames, each carrying one 2-bit x, y and t sample. It checks framing and, optionally, parity, then packs good frames into the averager's byte format {p=2'b11, t, y, x}. Packed bytes are buffered in a 4-entry FIFO and drained over a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, number of buffered packed samples (power of two, ≥2)
- ERR_CNT_W, 4, width of the saturating frame-error counter
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous, active-high reset; the name is kept for pin compatibility
- sdi  input  1  serial data bit
- sdi_valid  input  1  sdi is sampled only on cycles where this is 1
- out_data  output  8  packed sample {2'b11, t[1:0], y[1:0], x[1:0]}; 8'h00 when out_valid=0
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  consumer accepts the head this cycle
- busy  output  1  FSM not in IDLE
- err_pulse  output  1  one-cycle pulse on a rejected frame
- err_cnt  output  ERR_CNT_W  count of rejected frames, saturating
- overflow  output  1  sticky; set when a good frame is dropped because the FIFO is full

## Operation
- The frame is sent first to last: start bit (1), x1, x0, y1, y0, t1, t0, parity (even over the 6 data bits), stop bit (0).
- FSM states: IDLE, DATA, PARITY, STOP.
- Every transition consumes exactly one sdi_valid=1 cycle.
- IDLE: a valid bit with sdi=1 moves to DATA. A valid 0 is ignored.
- DATA: shift in 6 bits, then move to PARITY.
- PARITY: latch the parity mismatch, then move to STOP.
- STOP: always return to IDLE.
  - Good frame (sdi=0 and no parity mismatch): push the packed byte.
  - Otherwise: reject the frame.
- Reject: err_pulse is asserted and err_cnt increments, saturating at all-ones. Nothing is pushed.
- Cycles with sdi_valid=0 stall the FSM in place. A frame has no timeout.
- FIFO behaviour:
  - A pop occurs when out_valid && out_ready.
  - A push while full is allowed only if a pop happens in the same cycle. Otherwise the frame is dropped and overflow is set.
  - Push and pop in the same cycle while empty: the new entry becomes valid the next cycle; it does not pass through.
- overflow clears only on reset. A dropped frame does not count as an error.
- Reset, including mid-frame: FSM goes to IDLE and any partial frame is discarded. FIFO is emptied. err_cnt=0, overflow=0.
- Reset values: out_valid=0, out_data=8'h00, busy=0, err_pulse=0, err_cnt=0, overflow=0.

## Timing
- The stop bit is sampled on the edge at cycle N. For a good frame, out_valid=1 and out_data are valid from cycle N+1 (1-cycle latency into an empty FIFO).
- err_pulse is high for exactly cycle N+1 on a reject.
- busy is high from the cycle after the start bit is sampled through the cycle the stop bit is sampled. It is low from N+1.
- out_data and out_valid are registered outputs. They are stable while out_valid && !out_ready.
- Minimum frame spacing: a back-to-back start bit on the cycle after the stop bit is accepted.
- Peak throughput: one frame per 9 valid bits.

## Configuration
- FRAMER_PARITY_EN defined: the PARITY state exists, the frame is 9 bits and a parity mismatch rejects the frame.
- FRAMER_PARITY_EN undefined: the PARITY state is removed, the frame is 8 bits (start, 6 data, stop) and only stop-bit errors reject a frame.

## Structure
- Package framer_pkg holds:
  - the FSM state enum
  - DATA_BITS=6
  - HEADER=2'b11
  - the packing function from {t,y,x} to the byte
- Sub-module sample_fifo: a synchronous FIFO, parameterised by width and depth, exposing full, empty, push and pop. The top-level FSM and error counter instantiate it.

## Test plan
- Good frame, parity enabled: sdi 1,0,1,1,0,1,1,0,0 on consecutive valid cycles with out_ready=1 -> out_valid for one cycle at N+1 with out_data=8'hF9. err_cnt stays 0.
- Parity error: same frame with the parity bit set to 1 -> no out_valid, err_pulse high for one cycle at N+1, err_cnt=1.
- Stop error: stop bit 1 -> reject, err_cnt increments. 17 rejects -> err_cnt saturates at 4'hF.
- Overflow: 5 good frames with out_ready=0 -> 4 entries held, overflow=1. Then out_ready=1 -> exactly 4 bytes drain in order.
- Stall and idle: random sdi_valid=0 gaps inside a frame, and 0-bits in IDLE -> same 8'hF9 output with no spurious start.
- Reset mid-frame: assert rst_n after 4 data bits with one entry queued -> all outputs at reset values next cycle. The next full frame decodes correctly.
